ssm_io_sequencer: RTL
=====================

// Module: ssm_io_sequencer
// PURPOSE
//  Host-side driver/collector for ssm_block_fp16_top: the other end of its start/done + flat-bus interface.
//  Deserializes an FP16 word stream (valid/ready) into dt/dA/Bmat/C/D/x/h_prev flat registers,
//  pulses start, waits for done, captures y_flat and streams it back one FP16 word at a time.
//  Sits between the system interconnect and the SSM block; replaces hand-driven bench stimulus.
// PARAMETERS
//  B        1    batch size
//  H        4    heads
//  P        4    head dim
//  N        4    state dim
//  DW       16   FP16 word width
//  TIMEOUT  1024 max cycles in WAIT before done is declared lost
// PORTS
//  clk          in   1            clock, all logic rising-edge
//  rst          in   1            asynchronous, active-low reset
//  s_valid      in   1            input word valid
//  s_data       in   DW           input FP16 word
//  s_ready      out  1            input word accepted when s_valid&s_ready
//  ssm_start    out  1            one-cycle start pulse to SSM block
//  ssm_done     in   1            SSM completion (level or pulse)
//  ssm_y_flat   in   B*H*P*DW     SSM result bus
//  dt_flat      out  B*H*DW       loaded operands, held stable from start until next frame load
//  dA_flat      out  B*H*DW
//  Bmat_flat    out  B*N*DW
//  C_flat       out  B*N*DW
//  D_flat       out  H*DW
//  x_flat       out  B*H*P*DW
//  h_prev_flat  out  B*H*P*N*DW
//  m_valid      out  1            output word valid
//  m_data       out  DW           output FP16 word (y element)
//  m_last       out  1            high with final y word of frame
//  m_ready      in   1            downstream ready
//  busy         out  1            high in any state except LOAD with word count 0
//  err          out  1            sticky timeout flag; cleared on first word accepted of next frame
// BEHAVIOUR
//  Reset: state=LOAD, counters=0, all flat regs=0, s_ready=1, ssm_start=0, m_valid=0, m_last=0, m_data=0, busy=0, err=0.
//  Frame = NW = 2BH+2BN+H+BHP+BHPN words (default 100), fixed order: dt,dA,Bmat,C,D,x,h_prev;
//   within a field word k lands in bits [DW*k +: DW] (flat index ascending, matches SSM top layout).
//  LOAD: s_ready=1; each handshake writes word at running index, index++. Handshake on word NW-1 -> START.
//  START: ssm_start=1 for exactly one cycle (cycle T+1 after last-word handshake at T) -> WAIT.
//  WAIT: s_ready=0; timeout counter ++ per cycle. ssm_done sampled high -> latch ssm_y_flat into y reg -> DRAIN
//   (m_valid=1 next cycle). Counter reaching TIMEOUT without done -> err=1, -> LOAD, no output emitted.
//   ssm_done high during START cycle is ignored; ssm_done outside WAIT ignored entirely.
//  DRAIN: emits BHP words, index 0 first; m_data/m_last stable while m_valid&!m_ready.
//   m_last=1 only on index BHP-1; handshake on it -> LOAD, index=0, m_valid=0 next cycle.
//  No overlap: s_ready=0 in START/WAIT/DRAIN; back-to-back frames cost >=1 bubble each side.
//  Flat outputs hold last loaded values through WAIT/DRAIN; overwritten word-by-word in next LOAD.
//  Reset mid-operation (any state): immediate return to reset values; partially loaded frame discarded.
//  s_data with s_valid=0 never written; m_ready ignored when m_valid=0.
// STRUCTURE
//  ssm_pkg: localparams NW, field base offsets (OFF_DT..OFF_HP), NY=B*H*P, state encoding (LOAD,START,WAIT,DRAIN),
//   FP16 constants (FP16_ONE=16'h3C00, FP16_TWO=16'h4000, FP16_ZERO=16'h0000).
//  Sub-module ssm_y_serializer: captures y on done, drives m_valid/m_data/m_last with hold-under-backpressure.
//  Top: load FSM, field decode by offset compare, timeout counter.
// TESTING
//  1 Reset then 100 words (dt,dA,x,D,C=3C00; Bmat=4000; h_prev=0) with real SSM top -> one ssm_start pulse; 16 words all 0x4880, m_last on 16th.
//  2 s_valid toggled every other cycle during load -> flat buses identical to test 1, start only after word 100.
//  3 m_ready low 5 cycles mid-drain at word 7 -> m_data/m_last held stable, no word lost or duplicated.
//  4 Stub SSM never raises done -> err=1 after TIMEOUT cycles, state LOAD, no m_valid; err clears on next accepted word.
//  5 rst asserted after 50 input words -> all outputs at reset values; fresh 100-word frame completes normally.
//  6 Stub asserts done during START cycle and again in WAIT -> capture only on WAIT done; spurious done in LOAD has no effect.

Source files
------------

// File: rtl/ssm_pkg.sv
// Shared types and constants for the SSM host-side sequencer.
package ssm_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  function automatic int frame_words(input int b, input int h, input int p, input int n);
    return 2*b*h + 2*b*n + h + b*h*p + b*h*p*n;
  endfunction

  // Default-geometry layout (B=1, H=4, P=4, N=4), offsets in words
  localparam int NW     = frame_words(1, 4, 4, 4);
  localparam int NY     = 1*4*4;
  localparam int OFF_DT = 0;
  localparam int OFF_DA = OFF_DT + 1*4;
  localparam int OFF_BM = OFF_DA + 1*4;
  localparam int OFF_C  = OFF_BM + 1*4;
  localparam int OFF_D  = OFF_C  + 1*4;
  localparam int OFF_X  = OFF_D  + 4;
  localparam int OFF_HP = OFF_X  + 1*4*4;

  localparam logic [15:0] FP16_ZERO = 16'h0000;
  localparam logic [15:0] FP16_ONE  = 16'h3C00;
  localparam logic [15:0] FP16_TWO  = 16'h4000;

endpackage

// File: rtl/ssm_y_serializer.sv
// Captures the SSM result bus and streams it out one word at a time.
module ssm_y_serializer #(
  parameter int NY = 16,
  parameter int DW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture,
  input  logic [NY*DW-1:0] y_in,
  input  logic             m_ready,
  output logic             m_valid,
  output logic [DW-1:0]    m_data,
  output logic             m_last,
  output logic             frame_done
);

  localparam int IW = (NY > 1) ? $clog2(NY) : 1;

  logic [NY*DW-1:0] y_q;
  logic [IW-1:0]    idx_q;
  logic             valid_q;
  logic             is_last;
  logic             xfer;

  assign is_last    = (idx_q == IW'(NY-1));
  assign xfer       = valid_q & m_ready;
  assign m_valid    = valid_q;
  // Data is indexed from the held register, so it cannot move while stalled
  assign m_data     = y_q[idx_q*DW +: DW];
  assign m_last     = valid_q & is_last;
  assign frame_done = xfer & is_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_q     <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else if (capture) begin
      y_q     <= y_in;
      idx_q   <= '0;
      valid_q <= 1'b1;
    end else if (xfer) begin
      if (is_last) begin
        idx_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ssm_io_sequencer.sv
// Host-side loader/collector for the SSM block: word stream in, start/done, word stream out.
module ssm_io_sequencer
  import ssm_pkg::*;
#(
  parameter int B       = 1,
  parameter int H       = 4,
  parameter int P       = 4,
  parameter int N       = 4,
  parameter int DW      = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [DW-1:0]         s_data,
  output logic                  s_ready,
  output logic                  ssm_start,
  input  logic                  ssm_done,
  input  logic [B*H*P*DW-1:0]   ssm_y_flat,
  output logic [B*H*DW-1:0]     dt_flat,
  output logic [B*H*DW-1:0]     dA_flat,
  output logic [B*N*DW-1:0]     Bmat_flat,
  output logic [B*N*DW-1:0]     C_flat,
  output logic [H*DW-1:0]       D_flat,
  output logic [B*H*P*DW-1:0]   x_flat,
  output logic [B*H*P*N*DW-1:0] h_prev_flat,
  output logic                  m_valid,
  output logic [DW-1:0]         m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  err
);

  localparam int NWORDS = frame_words(B, H, P, N);
  localparam int NYW    = B*H*P;
  localparam int O_DT   = 0;
  localparam int O_DA   = O_DT + B*H;
  localparam int O_BM   = O_DA + B*H;
  localparam int O_C    = O_BM + B*N;
  localparam int O_D    = O_C  + B*N;
  localparam int O_X    = O_D  + H;
  localparam int O_HP   = O_X  + B*H*P;
  localparam int IW     = $clog2(NWORDS);
  localparam int TW     = $clog2(TIMEOUT + 1);

  state_t                 state_q, state_d;
  logic [IW-1:0]          idx_q;
  logic [TW-1:0]          tcnt_q;
  logic [NWORDS*DW-1:0]   frame_q;
  logic                   err_q;
  logic                   capture;
  logic                   y_done;
  logic                   last_word;
  logic                   expired;

  assign last_word = (idx_q == IW'(NWORDS-1));
  assign expired   = (tcnt_q == TW'(TIMEOUT-1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= LOAD;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    s_ready   = 1'b0;
    ssm_start = 1'b0;
    capture   = 1'b0;
    case (state_q)
      LOAD: begin
        s_ready = 1'b1;
        if (s_valid && last_word) state_d = START;
      end
      START: begin
        ssm_start = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (ssm_done) begin
          capture = 1'b1;
          state_d = DRAIN;
        end else if (expired) begin
          state_d = LOAD;
        end
      end
      DRAIN: begin
        if (y_done) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  // The frame lives in one register; the field buses are fixed slices of it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_q <= '0;
      idx_q   <= '0;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (s_valid && s_ready) begin
        frame_q[idx_q*DW +: DW] <= s_data;
        idx_q                   <= last_word ? '0 : idx_q + 1'b1;
        err_q                   <= 1'b0;
      end
      tcnt_q <= (state_q == WAIT) ? tcnt_q + 1'b1 : '0;
      if (state_q == WAIT && !ssm_done && expired) err_q <= 1'b1;
    end
  end

  assign dt_flat     = frame_q[O_DT*DW +: B*H*DW];
  assign dA_flat     = frame_q[O_DA*DW +: B*H*DW];
  assign Bmat_flat   = frame_q[O_BM*DW +: B*N*DW];
  assign C_flat      = frame_q[O_C*DW  +: B*N*DW];
  assign D_flat      = frame_q[O_D*DW  +: H*DW];
  assign x_flat      = frame_q[O_X*DW  +: B*H*P*DW];
  assign h_prev_flat = frame_q[O_HP*DW +: B*H*P*N*DW];

  assign busy = !(state_q == LOAD && idx_q == '0);
  assign err  = err_q;

  ssm_y_serializer #(
    .NY (NYW),
    .DW (DW)
  ) u_ser (
    .clk        (clk),
    .rst        (rst),
    .capture    (capture),
    .y_in       (ssm_y_flat),
    .m_ready    (m_ready),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_last     (m_last),
    .frame_done (y_done)
  );

endmodule
